sd_cmd_sequencer: RTL and testbench

// - Owns the SD CMD line transmitter (cmd_write) and the response receiver handshake.
// - Arbitrates two command sources onto the single CMD line: host CMD register and

---
 rtl/sd_cmd_pkg.sv | 31 +++
 rtl/sd_cmd_sequencer_counter.sv | 23 ++
 rtl/sd_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// SD command sequencer shared types.
// Response kinds, FSM states and the per-command status word.
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_48   = 2'd1,
        RSP_136  = 2'd2,
        RSP_48B  = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_TX,
        WAIT_RSP,
        RSP_RX,
        GAP,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic src_stop;
        logic timeout;
        logic crc_err;
        logic rsp_seen;
    } cmd_status_t;

    localparam logic [5:0] CMD12_IDX = 6'd12;

endpackage

// File: rtl/sd_cmd_sequencer_counter.sv
// Saturating up-counter used for NCR timeout and NCC gap timing.
// Clear wins over enable; the count sticks at all-ones.
module sd_cmd_sequencer_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (clear_i) begin
            q_o <= '0;
        end else if (en_i && (q_o != '1)) begin
            q_o <= q_o + 1'b1;
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD CMD line sequencer: arbitrates host and auto-CMD12 requests,
// drives the transmitter, times the response and the NCC gap.
import sd_cmd_pkg::*;

module sd_cmd_sequencer #(
    parameter int unsigned RspTimeout = 64,
    parameter int unsigned NccCycles  = 8,
    parameter int unsigned CntWidth   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_p_i,
    input  logic        host_req_i,
    input  logic [5:0]  host_idx_i,
    input  logic [31:0] host_arg_i,
    input  rsp_type_e   host_rsp_i,
    output logic        host_ack_o,
    input  logic        stop_req_i,
    input  logic [31:0] stop_arg_i,
    output logic        stop_ack_o,
    output logic        start_tx_o,
    output logic [5:0]  cmd_nr_o,
    output logic [31:0] cmd_argument_o,
    input  logic        tx_done_i,
    input  logic        rsp_start_i,
    input  logic        rsp_done_i,
    input  logic        rsp_crc_err_i,
    output logic        rsp_long_o,
    output logic        done_o,
    output logic [3:0]  status_o,
    output logic        busy_o
);

    localparam logic [CntWidth-1:0] RspTo = CntWidth'(RspTimeout);
    localparam logic [CntWidth-1:0] NccTo = CntWidth'(NccCycles);

    seq_state_e  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    rsp_type_e   rsp_q, rsp_d;
    cmd_status_t wk_q, wk_d;
    cmd_status_t status_q, status_d;
    logic        host_ack_q, host_ack_d;
    logic        stop_ack_q, stop_ack_d;
    logic        cnt_clr, cnt_en;
    logic [CntWidth-1:0] cnt;

    sd_cmd_sequencer_counter #(
        .Width (CntWidth)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .q_o     (cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            arg_q      <= '0;
            rsp_q      <= RSP_NONE;
            wk_q       <= '0;
            status_q   <= '0;
            host_ack_q <= 1'b0;
            stop_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            rsp_q      <= rsp_d;
            wk_q       <= wk_d;
            status_q   <= status_d;
            host_ack_q <= host_ack_d;
            stop_ack_q <= stop_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        rsp_d      = rsp_q;
        wk_d       = wk_q;
        host_ack_d = 1'b0;
        stop_ack_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Auto-CMD12 must not wait behind a host command.
                if (stop_req_i) begin
                    stop_ack_d    = 1'b1;
                    idx_d         = CMD12_IDX;
                    arg_d         = stop_arg_i;
                    rsp_d         = RSP_48;
                    wk_d          = '0;
                    wk_d.src_stop = 1'b1;
                    state_d       = ISSUE;
                end else if (host_req_i) begin
                    host_ack_d = 1'b1;
                    idx_d      = host_idx_i;
                    arg_d      = host_arg_i;
                    rsp_d      = host_rsp_i;
                    wk_d       = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!tx_done_i) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_i) begin
                    cnt_clr = 1'b1;
                    state_d = (rsp_q == RSP_NONE) ? GAP : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                cnt_en = clk_en_p_i;
                if (rsp_start_i) begin
                    state_d = RSP_RX;
                end else if (cnt == RspTo) begin
                    wk_d.timeout = 1'b1;
                    state_d      = DONE;
                end
            end
            RSP_RX: begin
                if (rsp_done_i) begin
                    wk_d.crc_err  = rsp_crc_err_i;
                    wk_d.rsp_seen = 1'b1;
                    cnt_clr       = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                cnt_en = clk_en_p_i;
                if (cnt == NccTo) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        status_d = (state_d == DONE) ? wk_d : status_q;
    end

    assign host_ack_o     = host_ack_q;
    assign stop_ack_o     = stop_ack_q;
    assign start_tx_o     = (state_q == ISSUE);
    assign cmd_nr_o       = idx_q;
    assign cmd_argument_o = arg_q;
    assign rsp_long_o     = ((state_q == WAIT_RSP) || (state_q == RSP_RX))
                            && (rsp_q == RSP_136);
    assign done_o         = (state_q == DONE);
    assign status_o       = status_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer with a hand-driven transmitter
// and receiver; expected status words are queued as commands are sent.
module tb_sd_cmd_sequencer;
    import sd_cmd_pkg::*;

    localparam int RSP_TO = 64;
    localparam int NCC    = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clk_en_p_i;
    logic        host_req_i;
    logic [5:0]  host_idx_i;
    logic [31:0] host_arg_i;
    rsp_type_e   host_rsp_i;
    logic        host_ack_o;
    logic        stop_req_i;
    logic [31:0] stop_arg_i;
    logic        stop_ack_o;
    logic        start_tx_o;
    logic [5:0]  cmd_nr_o;
    logic [31:0] cmd_argument_o;
    logic        tx_done_i;
    logic        rsp_start_i;
    logic        rsp_done_i;
    logic        rsp_crc_err_i;
    logic        rsp_long_o;
    logic        done_o;
    logic [3:0]  status_o;
    logic        busy_o;

    cmd_status_t sb_q[$];
    cmd_status_t mon_exp;
    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    sd_cmd_sequencer #(
        .RspTimeout (RSP_TO),
        .NccCycles  (NCC),
        .CntWidth   (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clk_en_p_i     (clk_en_p_i),
        .host_req_i     (host_req_i),
        .host_idx_i     (host_idx_i),
        .host_arg_i     (host_arg_i),
        .host_rsp_i     (host_rsp_i),
        .host_ack_o     (host_ack_o),
        .stop_req_i     (stop_req_i),
        .stop_arg_i     (stop_arg_i),
        .stop_ack_o     (stop_ack_o),
        .start_tx_o     (start_tx_o),
        .cmd_nr_o       (cmd_nr_o),
        .cmd_argument_o (cmd_argument_o),
        .tx_done_i      (tx_done_i),
        .rsp_start_i    (rsp_start_i),
        .rsp_done_i     (rsp_done_i),
        .rsp_crc_err_i  (rsp_crc_err_i),
        .rsp_long_o     (rsp_long_o),
        .done_o         (done_o),
        .status_o       (status_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Every done_o pops one expected status; an empty queue means a stray done.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done status=%b", status_o);
            end else begin
                mon_exp = sb_q.pop_front();
                if (status_o !== mon_exp) begin
                    n_err++;
                    $display("FAIL status got=%b exp=%b", status_o, mon_exp);
                end
            end
        end
    end

    task automatic send_host(input logic [5:0] idx, input logic [31:0] arg,
                             input rsp_type_e rsp);
        host_req_i = 1'b1;
        host_idx_i = idx;
        host_arg_i = arg;
        host_rsp_i = rsp;
        @(negedge clk);
        n_vec++;
        if (host_ack_o !== 1'b1 || stop_ack_o !== 1'b0
            || start_tx_o !== 1'b1 || cmd_nr_o !== idx) begin
            n_err++;
            $display("FAIL host_accept ack=%b stop_ack=%b start=%b nr=%0d exp_nr=%0d",
                     host_ack_o, stop_ack_o, start_tx_o, cmd_nr_o, idx);
        end
        host_req_i = 1'b0;
    endtask

    // Transmitter model: busy for a few cycles, then back to idle.
    task automatic tx_phase(input logic [5:0] idx, input logic [31:0] arg);
        logic bad;
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (start_tx_o !== 1'b1 || cmd_argument_o !== arg) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL start_hold start=%b exp=1", start_tx_o);
        end
        tx_done_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (start_tx_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_drop start=%b exp=0", start_tx_o);
        end
        bad = 1'b0;
        repeat (5) begin
            if (cmd_nr_o !== idx || cmd_argument_o !== arg) bad = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL cmd_stable nr=%0d arg=%h exp_nr=%0d exp_arg=%h",
                     cmd_nr_o, cmd_argument_o, idx, arg);
        end
        tx_done_i = 1'b1;
    endtask

    task automatic wait_done(input int lim, output int lat);
        lat = 0;
        while (lat < lim) begin
            @(negedge clk);
            lat++;
            if (done_o === 1'b1) break;
        end
        if (done_o !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout waited=%0d done=%b exp=1", lat, done_o);
        end
    endtask

    task automatic pulse_start();
        rsp_start_i = 1'b1;
        @(negedge clk);
        rsp_start_i = 1'b0;
    endtask

    task automatic pulse_done(input logic crc);
        rsp_done_i    = 1'b1;
        rsp_crc_err_i = crc;
        @(negedge clk);
        rsp_done_i    = 1'b0;
        rsp_crc_err_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy_o, start_tx_o, done_o, host_ack_o, stop_ack_o, rsp_long_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {busy_o, start_tx_o, done_o, host_ack_o, stop_ack_o, rsp_long_o});
        end
        n_vec++;
        if (status_o !== 4'b0 || cmd_nr_o !== 6'd0 || cmd_argument_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data status=%b nr=%0d arg=%h exp=0",
                     status_o, cmd_nr_o, cmd_argument_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd0_none();
        int lat;
        sb_q.push_back(4'b0000);
        send_host(6'd0, 32'h0, RSP_NONE);
        tx_phase(6'd0, 32'h0);
        wait_done(NCC + 10, lat);
        n_vec++;
        if (lat !== NCC + 2) begin
            n_err++;
            $display("FAIL gap_latency got=%0d exp=%0d", lat, NCC + 2);
        end
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_done busy=%b done=%b exp=0", busy_o, done_o);
        end
    endtask

    task automatic test_cmd17();
        int   lat;
        logic bad;
        sb_q.push_back(4'b0001);
        send_host(6'd17, 32'h0000_1000, RSP_48);
        tx_phase(6'd17, 32'h0000_1000);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_long_o !== 1'b0 || busy_o !== 1'b1) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL wait_rsp long=%b busy=%b exp long=0 busy=1", rsp_long_o, busy_o);
        end
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_done(1'b0);
        wait_done(NCC + 6, lat);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat;
        sb_q.push_back(4'b0100);
        send_host(6'd13, 32'hABCD_0000, RSP_48);
        tx_phase(6'd13, 32'hABCD_0000);
        wait_done(RSP_TO + 10, lat);
        n_vec++;
        if (lat !== RSP_TO + 2) begin
            n_err++;
            $display("FAIL timeout_latency got=%0d exp=%0d", lat, RSP_TO + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_start_at_terminal();
        int lat;
        sb_q.push_back(4'b0001);
        send_host(6'd13, 32'h1234_5678, RSP_48);
        tx_phase(6'd13, 32'h1234_5678);
        repeat (RSP_TO + 1) @(negedge clk);
        pulse_start();
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL start_wins done=%b busy=%b exp done=0 busy=1", done_o, busy_o);
        end
        repeat (2) @(negedge clk);
        pulse_done(1'b0);
        wait_done(NCC + 6, lat);
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int lat;
        int k;
        sb_q.push_back(4'b1001);
        sb_q.push_back(4'b0000);
        host_req_i = 1'b1;
        host_idx_i = 6'd7;
        host_arg_i = 32'h0055_0000;
        host_rsp_i = RSP_NONE;
        stop_req_i = 1'b1;
        stop_arg_i = 32'hCAFE_F00D;
        @(negedge clk);
        n_vec++;
        if (stop_ack_o !== 1'b1 || host_ack_o !== 1'b0 || cmd_nr_o !== 6'd12) begin
            n_err++;
            $display("FAIL stop_first stop_ack=%b host_ack=%b nr=%0d exp 1/0/12",
                     stop_ack_o, host_ack_o, cmd_nr_o);
        end
        stop_req_i = 1'b0;
        tx_phase(6'd12, 32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_done(1'b0);
        wait_done(NCC + 6, lat);
        k = 0;
        while (k < 6 && host_ack_o !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (host_ack_o !== 1'b1 || cmd_nr_o !== 6'd7) begin
            n_err++;
            $display("FAIL host_after_stop ack=%b nr=%0d exp ack=1 nr=7", host_ack_o, cmd_nr_o);
        end
        host_req_i = 1'b0;
        tx_phase(6'd7, 32'h0055_0000);
        wait_done(NCC + 6, lat);
        @(negedge clk);
    endtask

    task automatic test_crc_long();
        int lat;
        sb_q.push_back(4'b0011);
        send_host(6'd2, 32'h0, RSP_136);
        tx_phase(6'd2, 32'h0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (rsp_long_o !== 1'b1) begin
            n_err++;
            $display("FAIL rsp_long got=%b exp=1", rsp_long_o);
        end
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_done(1'b1);
        wait_done(NCC + 6, lat);
        @(negedge clk);
    endtask

    task automatic test_reset_midway();
        int saved;
        send_host(6'd17, 32'h0000_2000, RSP_48);
        tx_phase(6'd17, 32'h0000_2000);
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || start_tx_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midway busy=%b start=%b done=%b exp=0",
                     busy_o, start_tx_o, done_o);
        end
        rst_i = 1'b0;
        saved = done_cnt;
        repeat (RSP_TO + 20) @(negedge clk);
        n_vec++;
        if (done_cnt !== saved) begin
            n_err++;
            $display("FAIL no_done_after_reset got=%0d exp=%0d", done_cnt, saved);
        end
        test_cmd0_none();
    endtask

    task automatic test_stall();
        int saved;
        int lat;
        sb_q.push_back(4'b0000);
        send_host(6'd8, 32'h0000_01AA, RSP_NONE);
        tx_phase(6'd8, 32'h0000_01AA);
        clk_en_p_i = 1'b0;
        saved = done_cnt;
        repeat (5) @(negedge clk);
        pulse_start();
        pulse_done(1'b1);
        repeat (15) @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b1 || done_cnt !== saved) begin
            n_err++;
            $display("FAIL stall busy=%b dones=%0d exp busy=1 dones=%0d",
                     busy_o, done_cnt, saved);
        end
        clk_en_p_i = 1'b1;
        wait_done(NCC + 6, lat);
        @(negedge clk);
    endtask

    initial begin
        rst_i         = 1'b1;
        clk_en_p_i    = 1'b1;
        host_req_i    = 1'b0;
        host_idx_i    = '0;
        host_arg_i    = '0;
        host_rsp_i    = RSP_NONE;
        stop_req_i    = 1'b0;
        stop_arg_i    = '0;
        tx_done_i     = 1'b1;
        rsp_start_i   = 1'b0;
        rsp_done_i    = 1'b0;
        rsp_crc_err_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_cmd0_none();
        test_cmd17();
        test_timeout();
        test_start_at_terminal();
        test_arbitration();
        test_crc_long();
        test_reset_midway();
        test_stall();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
